// File: rtl/ibex_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// ibex_rf_wb_arbiter
//
// Purpose: schedules every register-file write in the core onto the two
// physical write ports (integer RF and FP RF). Three requesters compete on
// each port, with this fixed priority:
//   1. LSU load data: highest priority, cannot be stalled.
//   2. ID/EX results (valid/ready), or
//   3. the head of a small FIFO of multi-cycle FPU results.
// The order of 2 and 3 swaps once the FIFO head has been passed over for
// MaxStall cycles.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. ready may be high while valid is low. ready never depends on the
// valid of the same interface, so a producer may look at ready before it
// raises valid.
//
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   lsu_we_i/waddr_i/wdata_i/to_fp_i      LSU load write (no backpressure)
//   id_wb_valid_i/ready_o/waddr_i/wdata_i/to_fp_i
//                                         ID/EX result handshake
//   fpu_valid_i/ready_o/waddr_i/wdata_i/to_fp_i
//                                         FPU result into the FIFO
//   rf_we/waddr/wdata_int_o               integer RF write port
//   rf_we/waddr/wdata_fp_o                FP RF write port
//   fpu_pending_o                         FIFO is not empty
//   perf_wb_stall_o                       ID/EX result valid but not taken
// -----------------------------------------------------------------------------
module ibex_rf_wb_arbiter #(
   parameter int   FifoDepth = 2,
   parameter int   MaxStall  = 4,
   parameter logic ResetAll  = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        lsu_we_i,
   input  logic [4:0]  lsu_waddr_i,
   input  logic [31:0] lsu_wdata_i,
   input  logic        lsu_to_fp_i,
   input  logic        id_wb_valid_i,
   output logic        id_wb_ready_o,
   input  logic [4:0]  id_wb_waddr_i,
   input  logic [31:0] id_wb_wdata_i,
   input  logic        id_wb_to_fp_i,
   input  logic        fpu_valid_i,
   output logic        fpu_ready_o,
   input  logic [4:0]  fpu_waddr_i,
   input  logic [31:0] fpu_wdata_i,
   input  logic        fpu_to_fp_i,
   output logic        rf_we_int_o,
   output logic [4:0]  rf_waddr_int_o,
   output logic [31:0] rf_wdata_int_o,
   output logic        rf_we_fp_o,
   output logic [4:0]  rf_waddr_fp_o,
   output logic [31:0] rf_wdata_fp_o,
   output logic        fpu_pending_o,
   output logic        perf_wb_stall_o
);

   localparam int PtrW   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int CntW   = PtrW + 1;
   localparam int StallW = $clog2(MaxStall + 1);
   localparam logic [CntW-1:0]   DepthVal = CntW'(FifoDepth);
   localparam logic [StallW-1:0] StallMax = StallW'(MaxStall);

   // ---------------------------------------------------------------------------
   // FPU result FIFO
   // ---------------------------------------------------------------------------
   logic [4:0]        addr_q  [FifoDepth];
   logic [31:0]       data_q  [FifoDepth];
   logic              to_fp_q [FifoDepth];
   logic [PtrW-1:0]   wptr_q, rptr_q;
   logic [CntW-1:0]   count_q;
   logic [StallW-1:0] stall_q;

   logic        push, pop;
   logic        head_valid;
   logic [4:0]  head_addr;
   logic [31:0] head_data;
   logic        head_to_fp;
   logic        starve;

   assign head_valid = (count_q != '0);
   assign head_addr  = addr_q[rptr_q];
   assign head_data  = data_q[rptr_q];
   assign head_to_fp = to_fp_q[rptr_q];
   assign starve     = (stall_q == StallMax);

   // A full FIFO refuses a new entry even in a cycle where it pops.
   assign fpu_ready_o   = (count_q < DepthVal);
   assign fpu_pending_o = head_valid;
   assign push          = fpu_valid_i & fpu_ready_o;

   if (ResetAll) begin : g_store_rst
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < FifoDepth; i++) begin
               addr_q[i]  <= '0;
               data_q[i]  <= '0;
               to_fp_q[i] <= 1'b0;
            end
         end else if (push) begin
            addr_q[wptr_q]  <= fpu_waddr_i;
            data_q[wptr_q]  <= fpu_wdata_i;
            to_fp_q[wptr_q] <= fpu_to_fp_i;
         end
      end
   end else begin : g_store_norst
      always_ff @(posedge clk_i) begin
         if (push) begin
            addr_q[wptr_q]  <= fpu_waddr_i;
            data_q[wptr_q]  <= fpu_wdata_i;
            to_fp_q[wptr_q] <= fpu_to_fp_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         stall_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
         // Every cycle a valid head stays put counts, whether it lost to
         // ID/EX or to the LSU.
         if (!head_valid || pop)     stall_q <= '0;
         else if (stall_q != StallMax) stall_q <= stall_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Per-port arbitration
   // ---------------------------------------------------------------------------
   logic lsu_req_int, lsu_req_fp;
   logic id_req_int,  id_req_fp;
   logic hd_req_int,  hd_req_fp;
   logic g_lsu_int, g_id_int, g_hd_int;
   logic g_lsu_fp,  g_id_fp,  g_hd_fp;

   assign lsu_req_int = lsu_we_i & ~lsu_to_fp_i;
   assign lsu_req_fp  = lsu_we_i &  lsu_to_fp_i;
   assign id_req_int  = id_wb_valid_i & ~id_wb_to_fp_i;
   assign id_req_fp   = id_wb_valid_i &  id_wb_to_fp_i;
   assign hd_req_int  = head_valid & ~head_to_fp;
   assign hd_req_fp   = head_valid &  head_to_fp;

   // Grants are gated by rst_ni so nothing is written while in reset.
   assign g_lsu_int = rst_ni & lsu_req_int;
   assign g_id_int  = rst_ni & id_req_int & ~lsu_req_int & ~(starve & hd_req_int);
   assign g_hd_int  = rst_ni & hd_req_int & ~lsu_req_int & ~(~starve & id_req_int);
   assign g_lsu_fp  = rst_ni & lsu_req_fp;
   assign g_id_fp   = rst_ni & id_req_fp & ~lsu_req_fp & ~(starve & hd_req_fp);
   assign g_hd_fp   = rst_ni & hd_req_fp & ~lsu_req_fp & ~(~starve & id_req_fp);

   assign pop = g_hd_int | g_hd_fp;

   // Target fields only: ready must not depend on id_wb_valid_i.
   assign id_wb_ready_o = ~(lsu_we_i & (lsu_to_fp_i == id_wb_to_fp_i)) &
                          ~(starve & head_valid & (head_to_fp == id_wb_to_fp_i));
   assign perf_wb_stall_o = id_wb_valid_i & ~id_wb_ready_o;

   // AND-OR output muxes: a port with no grant shows address and data 0.
   assign rf_waddr_int_o = ({5{g_lsu_int}} & lsu_waddr_i) |
                           ({5{g_id_int}}  & id_wb_waddr_i) |
                           ({5{g_hd_int}}  & head_addr);
   assign rf_wdata_int_o = ({32{g_lsu_int}} & lsu_wdata_i) |
                           ({32{g_id_int}}  & id_wb_wdata_i) |
                           ({32{g_hd_int}}  & head_data);
   // A write to x0 is consumed by the arbiter but never reaches the RF.
   assign rf_we_int_o    = (g_lsu_int | g_id_int | g_hd_int) & (rf_waddr_int_o != 5'd0);

   assign rf_waddr_fp_o  = ({5{g_lsu_fp}} & lsu_waddr_i) |
                           ({5{g_id_fp}}  & id_wb_waddr_i) |
                           ({5{g_hd_fp}}  & head_addr);
   assign rf_wdata_fp_o  = ({32{g_lsu_fp}} & lsu_wdata_i) |
                           ({32{g_id_fp}}  & id_wb_wdata_i) |
                           ({32{g_hd_fp}}  & head_data);
   assign rf_we_fp_o     = g_lsu_fp | g_id_fp | g_hd_fp;

   a_onehot_int : assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0({g_lsu_int, g_id_int, g_hd_int}));
   a_onehot_fp : assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0({g_lsu_fp, g_id_fp, g_hd_fp}));

endmodule
